// File: rtl/sram_wl_sequencer.sv
// SRAM wordline sequencer: registered one-hot read/write wordlines
// with a small FIFO of deferred writes for blocked write cycles.
module sram_wl_sequencer #(
  parameter int ROWS     = 128,
  parameter int AW       = $clog2(ROWS),
  parameter int NRD      = 2,
  parameter int WQ_DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NRD-1:0]                  rd_en,
  input  logic [NRD*AW-1:0]               rd_addr,
  input  logic                            wr_en,
  input  logic [AW-1:0]                   wr_addr,
  output logic                            wr_ready,
  output logic [NRD*ROWS-1:0]             read_wl,
  output logic [ROWS-1:0]                 write_wl,
  output logic [AW-1:0]                   wr_issued_addr,
  output logic [NRD-1:0]                  rd_hazard,
  output logic [$clog2(WQ_DEPTH+1)-1:0]   wq_count,
  output logic                            addr_err,
  output logic                            wr_overflow
);

  localparam int CW = $clog2(WQ_DEPTH + 1);

  logic [AW-1:0] r_q [WQ_DEPTH];
  logic [AW-1:0] w_q_nxt [WQ_DEPTH];
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_tail;

  logic [NRD-1:0] w_rd_act;
  logic [NRD-1:0] w_rd_bad;
  logic [NRD-1:0] w_haz;
  logic           w_acc;
  logic           w_wr_ok;
  logic           w_wr_bad;
  logic           w_q_nemp;
  logic           w_cand_v;
  logic [AW-1:0]  w_cand;
  logic           w_conf;
  logic           w_issue;
  logic           w_deq;
  logic           w_enq;

  assign wq_count = r_cnt;
  assign wr_ready = (r_cnt < CW'(WQ_DEPTH));
  assign w_q_nemp = (r_cnt != '0);

  assign w_acc    = wr_en && wr_ready;
  assign w_wr_ok  = w_acc && (int'(wr_addr) < ROWS);
  assign w_wr_bad = w_acc && (int'(wr_addr) >= ROWS);

  // Classify each read port and look for queued rows it collides with.
  always_comb begin
    w_rd_act = '0;
    w_rd_bad = '0;
    w_haz    = '0;
    for (int i = 0; i < NRD; i++) begin
      w_rd_act[i] = rd_en[i] && (int'(rd_addr[i*AW +: AW]) < ROWS);
      w_rd_bad[i] = rd_en[i] && (int'(rd_addr[i*AW +: AW]) >= ROWS);
      for (int j = 0; j < WQ_DEPTH; j++) begin
        if (rd_en[i] && (CW'(j) < r_cnt) &&
            (r_q[j] == rd_addr[i*AW +: AW]))
          w_haz[i] = 1'b1;
      end
    end
  end

  // Pick the write candidate (queue head first) and decide on issue.
  always_comb begin
    w_cand_v = w_q_nemp || w_wr_ok;
    w_cand   = w_q_nemp ? r_q[0] : wr_addr;
    w_conf   = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      if (w_rd_act[i] && (rd_addr[i*AW +: AW] == w_cand))
        w_conf = 1'b1;
    end
    w_issue = w_cand_v && !(&w_rd_act) && !w_conf;
    w_deq   = w_issue && w_q_nemp;
    w_enq   = w_wr_ok && !(w_issue && !w_q_nemp);
  end

  // Next queue contents: shift out the head, append at the tail.
  always_comb begin
    w_tail    = r_cnt - CW'(w_deq);
    w_cnt_nxt = w_tail + CW'(w_enq);
    for (int j = 0; j < WQ_DEPTH; j++) begin
      w_q_nxt[j] = r_q[j];
      if (w_deq && (j < WQ_DEPTH - 1))
        w_q_nxt[j] = r_q[(j + 1) % WQ_DEPTH];
      if (w_enq && (CW'(j) == w_tail))
        w_q_nxt[j] = wr_addr;
    end
  end

  // Queue storage and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      for (int j = 0; j < WQ_DEPTH; j++)
        r_q[j] <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      for (int j = 0; j < WQ_DEPTH; j++)
        r_q[j] <= w_q_nxt[j];
    end
  end

  // Registered wordlines, hazards and sticky error flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      read_wl        <= '0;
      write_wl       <= '0;
      wr_issued_addr <= '0;
      rd_hazard      <= '0;
      addr_err       <= 1'b0;
      wr_overflow    <= 1'b0;
    end else begin
      for (int i = 0; i < NRD; i++) begin
        if (w_rd_act[i])
          read_wl[i*ROWS +: ROWS] <= ROWS'(1) << rd_addr[i*AW +: AW];
        else
          read_wl[i*ROWS +: ROWS] <= '0;
      end
      write_wl <= w_issue ? (ROWS'(1) << w_cand) : '0;
      if (w_issue)
        wr_issued_addr <= w_cand;
      rd_hazard <= w_haz;
      if (w_wr_bad || (|w_rd_bad))
        addr_err <= 1'b1;
      if (wr_en && !wr_ready)
        wr_overflow <= 1'b1;
    end
  end

endmodule

// File: doc/sram_wl_sequencer.md
Name: sram_wl_sequencer

Overview:
- Registered, parametrised wordline sequencer for the SRAM macro. Drives NRD read wordline vectors and one write wordline vector.
- Converts a blocked write (all read ports busy, or a same-row conflict) into a queued, deferred write instead of dropping it.
- Sits between the access controller and the bitcell array. All wordline outputs are flopped, so the array sees glitch-free one-hot lines.

Parameters:
- ROWS, 128, number of wordlines; need not be a power of two.
- AW, $clog2(ROWS), address width.
- NRD, 2, number of read ports (1..4).
- WQ_DEPTH, 2, deferred-write queue depth (1..8).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- rd_en  in  NRD  per-port read request.
- rd_addr  in  NRD*AW  per-port read row; port i uses bits [i*AW +: AW].
- wr_en  in  1  write request.
- wr_addr  in  AW  write row.
- wr_ready  out  1  write accepted this cycle if wr_en is high.
- read_wl  out  NRD*ROWS  one-hot read wordlines; port i uses bits [i*ROWS +: ROWS].
- write_wl  out  ROWS  one-hot write wordline.
- wr_issued_addr  out  AW  row driven on write_wl this cycle.
- rd_hazard  out  NRD  read row matches a queued (not yet written) row.
- wq_count  out  $clog2(WQ_DEPTH+1)  queue occupancy.
- addr_err  out  1  sticky out-of-range address flag.
- wr_overflow  out  1  sticky flag: write presented while wr_ready was low.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n low at an edge): read_wl, write_wl, wr_issued_addr, rd_hazard, wq_count, addr_err and wr_overflow all go to 0. Queue is emptied. Reset mid-operation discards queued writes with no wordline pulse.
- Latency: inputs sampled at edge N drive outputs valid for the cycle after edge N (one-cycle latency).
- Read path: read_wl[i] = 1<<rd_addr[i] when rd_en[i] is high and rd_addr[i] < ROWS; otherwise all zeros for that port.
- Out-of-range addresses: a read with rd_addr[i] >= ROWS, or an accepted write with wr_addr >= ROWS, sets addr_err. The bad write is discarded, not queued.
- Reads never stall. Two ports may read the same row.
- Write slot: available in a cycle iff the count of valid active reads is < NRD.
- Write candidate, in priority order:
  - queue head, if the queue is non-empty;
  - otherwise the incoming accepted write (bypass).
- Issue rule: the candidate issues iff the slot is available and its row differs from every active valid read row.
- On issue: write_wl = 1<<row and wr_issued_addr = row at the next edge. Otherwise write_wl = 0 and wr_issued_addr holds its previous value.
- Non-issue handling:
  - a non-issued queue head stays at the head;
  - an accepted incoming write that is not issued (head priority, no slot, or row conflict) is enqueued at the tail.
- FIFO order is strict: writes reach the array in acceptance order.
- wr_ready = (wq_count < WQ_DEPTH), computed from the registered count only. A full queue holds wr_ready low even if it dequeues that cycle.
- wr_en while wr_ready is low: the write is ignored and wr_overflow is set (sticky until reset).
- Same-cycle enqueue and dequeue: wq_count is unchanged.
- rd_hazard[i], registered with read_wl: set when rd_en[i] is high and rd_addr[i] equals any valid entry in the pre-update queue.
  - Same-cycle ordering is read before write, so a read and a new write to the same row in the same cycle is not a hazard.
  - A head entry issued that same cycle still counts as a hazard; its row has not yet been written.
- At most one write_wl bit is high at any time. A row never appears in write_wl and read_wl in the same cycle.

Test Plan:
- Reset with the queue holding 2 entries: rst_n low for 1 cycle -> all outputs 0, wq_count=0, wr_ready=1, no write_wl pulse afterwards.
- NRD=2, rd_en=01, rd_addr0=5, wr_en with wr_addr=9 -> next cycle read_wl port0 bit5=1, write_wl bit9=1, wq_count=0.
- rd_en=11 (rows 3, 4) with wr_addr=7 for 1 cycle, then rd_en=00 -> first cycle write_wl=0 and wq_count=1; second cycle write_wl bit7=1 and wq_count=0.
- Port0 reads row 7 for 2 cycles while a write to row 7 is queued; wr_en low, port1 idle -> rd_hazard[0]=1 both cycles; write deferred while the read holds row 7; issues the cycle after the read stops.
- Fill the queue (rd_en=11, 3 writes, WQ_DEPTH=2) -> third write sees wr_ready=0, wr_overflow=1, queued rows drain in acceptance order.
- ROWS=100, rd_addr=100 -> read_wl for that port=0, addr_err=1, flag held after the address returns to valid.
